// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The dma_lock signal exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_adr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;
`ifdef MEM_ARB_LOCK_EN
  logic          dma_lock;
`endif

  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;
  logic [1:0]    grant;

  // Arbiter side: requests and memory read data in, acks/data/strobes out.
  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_adr, dma_wdata,
    output dma_rdata, dma_ack,
`ifdef MEM_ARB_LOCK_EN
    input  dma_lock,
`endif
    output mem_adr, mem_wd, mem_we,
    input  mem_rd,
    output grant
  );

  // Environment side: requesters plus memory model.
  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_adr, dma_wdata,
    input  dma_rdata, dma_ack,
`ifdef MEM_ARB_LOCK_EN
    output dma_lock,
`endif
    input  mem_adr, mem_wd, mem_we,
    output mem_rd,
    input  grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for a single-port memory: fixed CPU priority with a DMA starvation bound.
// Optional DMA burst lock is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;
  localparam logic [3:0] MAX_W    = 4'(MAX_WAIT);

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic [3:0]    wait_q, wait_d;
  logic          win_any;
  logic          win_dma;
  logic          mem_we_o;
  logic          cpu_ack_o;
  logic          dma_ack_o;
`ifdef MEM_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic          locked_win;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wd_q        <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      wait_q      <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wd_q        <= wd_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      wait_q      <= wait_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wd_d        = wd_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    wait_d      = wait_q;
    win_any     = 1'b0;
    win_dma     = 1'b0;
    mem_we_o    = 1'b0;
    cpu_ack_o   = 1'b0;
    dma_ack_o   = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    lock_d      = lock_q;
    locked_win  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        win_any = bus.cpu_req | bus.dma_req;
        if (!bus.dma_req) wait_d = '0;
`ifdef MEM_ARB_LOCK_EN
        // A held lock keeps the next access for DMA and freezes the wait count.
        locked_win = lock_q & bus.dma_req & bus.dma_lock;
        lock_d     = 1'b0;
        if (locked_win) begin
          win_dma = 1'b1;
        end else
`endif
        if (bus.cpu_req && bus.dma_req) begin
          if (wait_q == MAX_W) begin
            win_dma = 1'b1;
            wait_d  = '0;
          end else begin
            // CPU only wins below MAX_W, so this increment saturates there.
            wait_d  = wait_q + 4'd1;
          end
        end else if (bus.dma_req) begin
          win_dma = 1'b1;
          wait_d  = '0;
        end

        if (win_any) begin
          state_d = SERVE;
          grant_d = win_dma ? GNT_DMA : GNT_CPU;
          we_d    = win_dma ? bus.dma_we    : bus.cpu_we;
          adr_d   = win_dma ? bus.dma_adr   : bus.cpu_adr;
          wd_d    = win_dma ? bus.dma_wdata : bus.cpu_wdata;
        end
      end

      SERVE: begin
        mem_we_o = we_q;
        if (!we_q) begin
          if (grant_q == GNT_DMA) dma_rdata_d = bus.mem_rd;
          else                    cpu_rdata_d = bus.mem_rd;
        end
        state_d = RESP;
      end

      RESP: begin
        cpu_ack_o = (grant_q == GNT_CPU);
        dma_ack_o = (grant_q == GNT_DMA);
`ifdef MEM_ARB_LOCK_EN
        lock_d    = (grant_q == GNT_DMA) & bus.dma_lock;
`endif
        grant_d   = GNT_NONE;
        state_d   = IDLE;
      end

      default: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_adr   = adr_q;
  assign bus.mem_wd    = wd_q;
  assign bus.mem_we    = mem_we_o;
  assign bus.grant     = grant_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_o;
  assign bus.dma_ack   = dma_ack_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level reference model.
// Compile with MEM_ARB_LOCK_EN defined to also exercise the DMA burst lock.
module tb_mem_arbiter;
  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Physical memory driven by the DUT, and the bench's own expected copy.
  logic [15:0] phys [0:65535];
  logic [15:0] model_mem [0:65535];
  assign bus.mem_rd = phys[bus.mem_adr];
  always @(posedge clk) if (bus.mem_we) phys[bus.mem_adr] = bus.mem_wd;

  int total = 0;
  int bad   = 0;
  int slot_no = 0;

  int          streak;
  bit          locked;
  logic [15:0] exp_cpu_rd;
  logic [15:0] exp_dma_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One arbitration decision starting in IDLE; returns the grant seen in SERVE.
  task automatic run_slot(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                          input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                          input logic dl, input logic pert, output logic [1:0] g_obs);
    logic [1:0]  w;
    logic        wwe;
    logic [15:0] wa, wd;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_adr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_adr = da; bus.dma_wdata = dd;
`ifdef MEM_ARB_LOCK_EN
    bus.dma_lock = dl;
`endif
    w = 2'd0;
    if (!dr) streak = 0;
`ifdef MEM_ARB_LOCK_EN
    if (locked && dr && dl) w = 2'd2;
`endif
    if (w == 2'd0) begin
      if (cr && dr) begin
        if (streak >= MAX_WAIT) begin w = 2'd2; streak = 0; end
        else begin w = 2'd1; streak++; end
      end else if (dr) begin
        w = 2'd2; streak = 0;
      end else if (cr) begin
        w = 2'd1;
      end
    end
    locked = 1'b0;
    wwe = (w == 2'd1) ? cw : dw;
    wa  = (w == 2'd1) ? ca : da;
    wd  = (w == 2'd1) ? cd : dd;

    @(posedge clk); #1;
    g_obs = bus.grant;
    slot_no++;
    $display("txn %0d: cpu_req=%0b dma_req=%0b grant=%0d we=%0b adr=%h", slot_no, cr, dr, bus.grant, wwe, wa);
    if (w == 2'd0) begin
      chk("idle_grant", bus.grant, 2'b00);
      chk("idle_ack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
      chk("idle_we", bus.mem_we, 1'b0);
      return;
    end
    chk("serve_grant", bus.grant, w);
    chk("serve_adr", bus.mem_adr, wa);
    chk("serve_wd", bus.mem_wd, wd);
    chk("serve_we", bus.mem_we, wwe);
    chk("serve_ack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
    if (pert) begin
      bus.cpu_adr = ca ^ 16'h0001; bus.cpu_wdata = ~cd; bus.cpu_req = ~cr;
      bus.dma_adr = da ^ 16'h0001; bus.dma_wdata = ~dd; bus.dma_req = ~dr;
    end

    @(posedge clk); #1;
    if (wwe)            model_mem[wa] = wd;
    else if (w == 2'd1) exp_cpu_rd = model_mem[wa];
    else                exp_dma_rd = model_mem[wa];
    chk("resp_ack", {bus.cpu_ack, bus.dma_ack}, (w == 2'd1) ? 2'b10 : 2'b01);
    chk("resp_we", bus.mem_we, 1'b0);
    chk("resp_adr_hold", bus.mem_adr, wa);
    chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
    chk("dma_rdata", bus.dma_rdata, exp_dma_rd);
    locked = (w == 2'd2) && dl;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;

    @(posedge clk); #1;
    chk("post_grant", bus.grant, 2'b00);
    chk("post_ack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] exp_pat [10];
    logic       found;
    exp_pat = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 65536; i++) begin
      phys[i]      = 16'($urandom);
      model_mem[i] = phys[i];
    end
    phys[16'h0020] = 16'h1234; model_mem[16'h0020] = 16'h1234;
    phys[16'h0040] = 16'hAAAA; model_mem[16'h0040] = 16'hAAAA;
    phys[16'h0041] = 16'h5555; model_mem[16'h0041] = 16'h5555;

    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_adr = '0; bus.dma_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    bus.dma_lock = 1'b0;
`endif
    streak = 0; locked = 1'b0; exp_cpu_rd = '0; exp_dma_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_ack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_adr", bus.mem_adr, 16'h0000);
    chk("rst_wd", bus.mem_wd, 16'h0000);
    chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // CPU write then read back.
    run_slot(1, 1, 16'h0010, 16'hBEEF, 0, 0, '0, '0, 0, 0, g);
    run_slot(1, 0, 16'h0010, 16'h0000, 0, 0, '0, '0, 0, 0, g);
    chk("cpu_rd_beef", bus.cpu_rdata, 16'hBEEF);

    // DMA read alone; CPU read data must stay put.
    run_slot(0, 0, '0, '0, 1, 0, 16'h0020, '0, 0, 0, g);
    chk("dma_alone_grant", g, 2'b10);
    chk("dma_rd_1234", bus.dma_rdata, 16'h1234);
    chk("cpu_rd_keep", bus.cpu_rdata, 16'hBEEF);

    // Both requesting continuously: four CPU wins then one DMA win, twice.
    for (int i = 0; i < 10; i++) begin
      run_slot(1, 1, 16'h0080 + 16'(i), 16'(i), 1, 1, 16'h0090 + 16'(i), 16'(i + 100), 0, 0, g);
      chk("starve_pattern", g, exp_pat[i]);
    end

    // Address changes after sampling are ignored.
    run_slot(1, 0, 16'h0040, '0, 0, 0, '0, '0, 0, 1, g);
    chk("adr_latch_rd", bus.cpu_rdata, 16'hAAAA);

    // Reset in the SERVE cycle of a CPU write.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 16'h0030; bus.cpu_wdata = 16'hDEAD;
    @(posedge clk); #1;
    chk("mid_serve_we", bus.mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", bus.mem_we, 1'b0);
    chk("mid_rst_grant", bus.grant, 2'b00);
    chk("mid_rst_adr", bus.mem_adr, 16'h0000);
    chk("mid_rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'h0);
    bus.cpu_req = 0;
    streak = 0; locked = 1'b0; exp_cpu_rd = '0; exp_dma_rd = '0;
    @(negedge clk); reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("mid_rst_noack", {bus.cpu_ack, bus.dma_ack}, 2'b00);
      chk("mid_rst_idle", bus.grant, 2'b00);
    end
    run_slot(1, 0, 16'h0010, '0, 0, 0, '0, '0, 0, 0, g);
    chk("restart_rd", bus.cpu_rdata, 16'hBEEF);

    // Randomized traffic on a separate address window.
    for (int i = 0; i < 300; i++) begin
      run_slot(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               16'h0100 + 16'($urandom_range(0, 255)), 16'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
               16'h0100 + 16'($urandom_range(0, 255)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g);
    end

`ifdef MEM_ARB_LOCK_EN
    // Locked burst: reach a DMA grant, keep two more, then release to CPU.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      run_slot(1, 0, 16'h0200, '0, 1, 0, 16'h0210, '0, 1, 0, g);
      found = (g == 2'b10);
    end
    chk("lock_reach", found, 1'b1);
    for (int i = 0; i < 2; i++) begin
      run_slot(1, 0, 16'h0200, '0, 1, 0, 16'h0211 + 16'(i), '0, 1, 0, g);
      chk("lock_burst", g, 2'b10);
    end
    run_slot(1, 0, 16'h0200, '0, 1, 0, 16'h0215, '0, 0, 0, g);
    chk("lock_release", g, 2'b01);
`else
    found = 1'b0;
    g = {1'b0, found};
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port 16-bit system memory. It sits between the multicycle core's memory port and the `mem` block. A second master (DMA/loader) shares the memory with the core. CPU has fixed priority, bounded by a starvation counter that guarantees DMA service. Every access is a registered three-phase transaction: arbitrate, drive memory, acknowledge.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `MAX_WAIT`, 4, consecutive CPU wins tolerated while DMA waits; legal range is 1–15

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU request, level
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_adr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  CPU read data, valid while `cpu_ack`=1
- `cpu_ack`  out  1  one-cycle completion pulse
- `dma_req`, `dma_we`, `dma_adr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same as the CPU set, for the DMA master
- `dma_lock`  in  1  burst lock (present only with `MEM_ARB_LOCK_EN`)
- `mem_adr`  out  AW  to memory `adr`
- `mem_wd`  out  DW  to memory write data
- `mem_we`  out  1  to memory `memwrite`
- `mem_rd`  in  DW  from memory `readdata` (combinational read)
- `grant`  out  2  owner: 00 none, 01 CPU, 10 DMA

## Operation
- FSM states: IDLE, SERVE, RESP.
- **IDLE**
  - Samples `*_req`. Requests are sampled only in IDLE.
  - If no request, stays in IDLE.
  - Otherwise picks a winner and registers its `we`, `adr` and `wdata` into `mem_adr`/`mem_wd` and the pending `we` bit.
  - Sets `grant` and moves to SERVE.
- **Winner selection**
  - Only one requester: that requester wins.
  - Both requesting: CPU wins unless `wait_cnt == MAX_WAIT`, in which case DMA wins.
- **`wait_cnt` updates**
  - Increments on each IDLE decision where both requested and CPU won.
  - Clears when DMA is granted, or when `dma_req`=0 in IDLE.
  - Saturates at `MAX_WAIT`.
- **SERVE**
  - `mem_we` = pending `we`. The memory writes on the closing edge.
  - For reads, `mem_rd` is captured into the owner's `*_rdata` register on the closing edge.
  - Always moves to RESP.
- **RESP**
  - Owner's `*_ack`=1 for exactly this cycle.
  - `mem_we`=0.
  - Moves to IDLE and clears `grant`.
- **Requester rule**: a requester must drop `req`, or present its next request, on the edge where it observes `ack`=1. A `req` still high in the following IDLE cycle is a new access.
- **Held values**
  - `*_rdata` holds its value until the next read for that requester.
  - A write leaves the requester's `*_rdata` unchanged.
  - `mem_adr`/`mem_wd` hold their last values outside SERVE.
- Each master sees only its own `ack`. The non-owner's `ack` is 0 at all times.

## Timing
- **Reset values**: state IDLE; `cpu_ack`, `dma_ack`, `mem_we` = 0; `grant` = 00; `mem_adr`, `mem_wd`, `cpu_rdata`, `dma_rdata`, `wait_cnt` = 0.
- **Latency**: request sampled in IDLE in cycle t, SERVE in t+1, `ack` in t+2. Back-to-back accesses run every 3 cycles.
- **Memory strobe**: `mem_we` is high only in SERVE, for exactly one cycle per write.
- **Reset mid-transaction**: aborts asynchronously. `mem_we` drops immediately, no `ack` is issued, and the interrupted write is not guaranteed.
- **Request changes after sampling**: changes to `req`/`adr`/`wdata` during SERVE or RESP are ignored, because the values were latched in IDLE.
- **Simultaneous first requests** after reset: CPU wins and `wait_cnt` becomes 1.
- **Zero-wait case**: a single requester gets no wait penalty. `wait_cnt` is only affected when both masters are requesting.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - `dma_lock` port exists.
  - If DMA owns the current transaction and `dma_lock`=1 in RESP, the next IDLE decision goes to DMA whenever `dma_req`=1, regardless of `cpu_req`.
  - `wait_cnt` is held during a locked burst.
  - Lock is released when `dma_lock`=0 or `dma_req`=0 in IDLE.
- `MEM_ARB_LOCK_EN` undefined: no `dma_lock` port and pure priority/starvation arbitration.

## Test plan
- **CPU write then read**: CPU writes 0xBEEF to 0x0010, then reads 0x0010.
  - `mem_we` high for exactly one cycle.
  - `cpu_ack` in t+2 for each access.
  - Read returns `cpu_rdata`=0xBEEF.
  - `dma_ack` stays 0 throughout.
- **Both requesting continuously** (`MAX_WAIT`=4):
  - Grants follow the order C, C, C, C, D, C, C, C, C, D.
  - `wait_cnt` returns to 0 after each D.
- **DMA read alone**: `dma_adr`=0x0020 holding 0x1234.
  - `grant`=10 during SERVE.
  - `dma_rdata`=0x1234 with `dma_ack` two cycles after the request.
  - `cpu_rdata` unchanged.
- **Reset mid-transaction**: assert `reset` in the SERVE cycle of a CPU write to 0x0030.
  - All outputs at reset values in the same cycle.
  - No `ack` is issued.
  - FSM restarts in IDLE.
- **Requests changing after sampling**: `cpu_adr` changes from 0x0040 to 0x0041 during SERVE.
  - `mem_adr` stays 0x0040.
  - Returned data comes from 0x0040.
- **Locked burst** (`MEM_ARB_LOCK_EN`, both requesting, `dma_lock`=1 after the DMA grant):
  - DMA receives 3 consecutive accesses.
  - CPU is granted in the first IDLE after `dma_lock`=0.
